ram_sp_pipe: RTL and testbench

//  Parametrised single-port CPU memory, successor to the 8-bit/32K flat RAM.

---
 rtl/ram_sp_pipe_pkg.sv | 18 +
 rtl/ram_sp_pipe_array.sv | 54 +++++
 rtl/ram_sp_pipe.sv | 164 ++++++++++++++++
 tb/tb_ram_sp_pipe.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_sp_pipe_pkg.sv
// Shared types and helpers for the ram_sp_pipe single-port memory.
// The optional lane-parity feature is enabled by defining MEM_PARITY_EN.
package ram_sp_pipe_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    // Deepest read pipeline the memory supports.
    localparam int RD_LAT_MAX = 4;

    // Number of 8-bit byte lanes in a word of the given width.
    function automatic int nb(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ram_sp_pipe_array.sv
// Raw DEPTH x DATA_W storage with byte-lane writes and an asynchronous read.
// When MEM_PARITY_EN is defined, one even-parity bit per lane is stored
// alongside the data and can be deliberately inverted on write.
module ram_sp_pipe_array
    import ram_sp_pipe_pkg::*;
#(
    parameter  int ADDR_W = 15,
    parameter  int DATA_W = 8,
    localparam int NB     = nb(DATA_W)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [NB-1:0]     wbe,
`ifdef MEM_PARITY_EN
    input  logic [NB-1:0]     winj,
    output logic [NB-1:0]     rpar,
`endif
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Update only the enabled byte lanes of the addressed word.
    // NOTE: the array has no reset; zeroing is done by the clear sweep in the top level.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

`ifdef MEM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];

    // Store one even-parity bit per written lane, inverted where injection is requested.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) par_mem[addr][i] <= (^wdata[8*i +: 8]) ^ winj[i];
            end
        end
    end

    assign rpar = par_mem[addr];
`endif

endmodule

// File: rtl/ram_sp_pipe.sv
// Single-port CPU memory: req/ready/valid handshake, byte-lane writes,
// RD_LAT-deep registered read path and a hardware clear sweep after reset.
// Defining MEM_PARITY_EN adds per-lane parity storage, par_inj and parity_err.
module ram_sp_pipe
    import ram_sp_pipe_pkg::*;
#(
    parameter  int ADDR_W       = 15,
    parameter  int DATA_W       = 8,
    parameter  int RD_LAT       = 1,
    parameter  int CLEAR_ON_RST = 1,
    localparam int NB           = nb(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] datain,
    input  logic [NB-1:0]     be,
`ifdef MEM_PARITY_EN
    input  logic [NB-1:0]     par_inj,
    output logic              parity_err,
`endif
    output logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] dataout
);

    // Pipeline depth, held inside the supported 1..RD_LAT_MAX range.
    localparam int LAT = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : ((RD_LAT < 1) ? 1 : RD_LAT);

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              ready_q;

    logic              clearing;
    logic              accept;
    logic              wr_acc;
    logic              rd_acc;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [NB-1:0]     arr_be;
    logic [DATA_W-1:0] arr_rdata;

    logic [LAT-1:0]    pipe_vld;
    logic [DATA_W-1:0] pipe_dat [LAT];

    assign clearing = (state == ST_CLEAR) && !rst;
    assign accept   = req && ready_q && !rst;
    assign wr_acc   = accept && we;
    assign rd_acc   = accept && !we;

    // Sequence the clear sweep and raise ready once the array is usable.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == '1) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef MEM_PARITY_EN
    logic [NB-1:0] arr_inj;
    logic [NB-1:0] arr_rpar;
`endif

    // Steer the single array port between the clear sweep and accepted writes.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path infers a latch.
        arr_we    = wr_acc;
        arr_addr  = address;
        arr_wdata = datain;
        arr_be    = be;
`ifdef MEM_PARITY_EN
        arr_inj   = par_inj;
`endif
        if (clearing) begin
            arr_we    = 1'b1;
            arr_addr  = clr_cnt;
            arr_wdata = '0;
            arr_be    = '1;
`ifdef MEM_PARITY_EN
            arr_inj   = '0;
`endif
        end
    end

    ram_sp_pipe_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .wr_en (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .wbe   (arr_be),
`ifdef MEM_PARITY_EN
        .winj  (arr_inj),
        .rpar  (arr_rpar),
`endif
        .rdata (arr_rdata)
    );

    // Carry read data through LAT stages; a stage keeps its data while no read passes.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < LAT; i++) pipe_dat[i] <= '0;
        end else begin
            pipe_vld[0] <= rd_acc;
            if (rd_acc) pipe_dat[0] <= arr_rdata;
            for (int i = 1; i < LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    assign ready   = ready_q;
    assign valid   = pipe_vld[LAT-1];
    assign dataout = pipe_dat[LAT-1];

`ifdef MEM_PARITY_EN
    logic [NB-1:0]  lane_err;
    logic [LAT-1:0] pipe_err;

    // Compare each returned lane against its stored parity bit.
    always_comb begin
        lane_err = '0;
        for (int i = 0; i < NB; i++) lane_err[i] = (^arr_rdata[8*i +: 8]) ^ arr_rpar[i];
    end

    // Move the parity verdict alongside its read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_err <= '0;
        end else begin
            if (rd_acc) pipe_err[0] <= |lane_err;
            for (int i = 1; i < LAT; i++) begin
                if (pipe_vld[i-1]) pipe_err[i] <= pipe_err[i-1];
            end
        end
    end

    assign parity_err = pipe_vld[LAT-1] && pipe_err[LAT-1];
`endif

endmodule

// File: tb/tb_ram_sp_pipe.sv
// Directed bench for ram_sp_pipe (ADDR_W=4, DATA_W=32, RD_LAT=3, CLEAR_ON_RST=1).
// Parity checks are compiled in when MEM_PARITY_EN is defined.
module tb_ram_sp_pipe;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 3;
    localparam int DEPTH  = 16;

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              req     = 1'b0;
    logic              we      = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] datain  = '0;
    logic [3:0]        be      = '0;
    logic              ready;
    logic              valid;
    logic [DATA_W-1:0] dataout;
`ifdef MEM_PARITY_EN
    logic [3:0]        par_inj  = '0;
    logic              parity_err;
    logic              exp_perr = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    ram_sp_pipe #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .RD_LAT       (RD_LAT),
        .CLEAR_ON_RST (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .address    (address),
        .datain     (datain),
        .be         (be),
`ifdef MEM_PARITY_EN
        .par_inj    (par_inj),
        .parity_err (parity_err),
`endif
        .ready      (ready),
        .valid      (valid),
        .dataout    (dataout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        req     = r;
        we      = w;
        address = a;
        datain  = d;
        be      = b;
    endtask

    function automatic logic [31:0] fill(input int a);
        return 32'h0101_0101 * 32'(a + 1);
    endfunction

    // Issue one read now; expect exactly one valid pulse RD_LAT cycles later, then held data.
    task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp_d);
        drive(1'b1, 1'b0, a, '0, '0);
        for (int j = 1; j <= RD_LAT + 2; j++) begin
            @(negedge clk);
            if (j == 1) drive(1'b0, 1'b0, '0, '0, '0);
            check($sformatf("%s_valid%0d", tag, j), 32'(valid), 32'(j == RD_LAT));
            if (j == RD_LAT) check({tag, "_data"}, dataout, exp_d);
`ifdef MEM_PARITY_EN
            check($sformatf("%s_perr%0d", tag, j), 32'(parity_err),
                  32'((j == RD_LAT) ? exp_perr : 1'b0));
`endif
        end
        check({tag, "_hold"}, dataout, exp_d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_dout", dataout, 32'd0);
`ifdef MEM_PARITY_EN
        check("rst_perr", 32'(parity_err), 32'd0);
`endif

        // First sweep: ready stays low for exactly DEPTH cycles.
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            @(negedge clk);
            check($sformatf("sweep1_ready%0d", i), 32'(ready), 32'(i == DEPTH));
        end

        // Fill every word with a non-zero pattern, one write per cycle.
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b1, 1'b1, 4'(a), fill(a), 4'hF);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, '0, '0, '0);

        // Byte-lane merge: lanes 0 and 2 overwritten.
        drive(1'b1, 1'b1, 4'd5, 32'hAABB_CCDD, 4'hF);
        @(negedge clk);
        drive(1'b1, 1'b1, 4'd5, 32'h1122_3344, 4'b0101);
        @(negedge clk);
        read_chk("be_merge", 4'd5, 32'hAA22_CC44);

        // be=0 write is a no-op.
        drive(1'b1, 1'b1, 4'd5, 32'h0000_0000, 4'b0000);
        @(negedge clk);
        read_chk("be_zero", 4'd5, 32'hAA22_CC44);

        // Write immediately followed by a read of the same address.
        drive(1'b1, 1'b1, 4'd7, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        read_chk("wr_rd", 4'd7, 32'hDEAD_BEEF);

        // Back-to-back reads of addresses 1, 2, 3.
        drive(1'b1, 1'b0, 4'd1, '0, '0);
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            check($sformatf("b2b_valid%0d", j), 32'(valid), 32'(j >= 3 && j <= 5));
            if (j >= 3 && j <= 5) check($sformatf("b2b_data%0d", j), dataout, fill(j - 2));
            if (j < 3) drive(1'b1, 1'b0, 4'(j + 1), '0, '0);
            else       drive(1'b0, 1'b0, '0, '0, '0);
        end

        // Reset with two reads in flight: both dropped.
        drive(1'b1, 1'b0, 4'd1, '0, '0);
        @(negedge clk);
        drive(1'b1, 1'b0, 4'd2, '0, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("flush_valid", 32'(valid), 32'd0);
        check("flush_dout", dataout, 32'd0);
        check("flush_ready", 32'(ready), 32'd0);

        // Writes requested during the sweep must be ignored.
        drive(1'b1, 1'b1, 4'd2, 32'h0000_00FF, 4'hF);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check($sformatf("sweep2_valid%0d", i), 32'(valid), 32'd0);
            check($sformatf("sweep2_ready%0d", i), 32'(ready), 32'd0);
        end

        // Reset mid-sweep: the full DEPTH-cycle sweep starts over from address 0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            @(negedge clk);
            check($sformatf("sweep3_ready%0d", i), 32'(ready), 32'(i == DEPTH));
            check($sformatf("sweep3_valid%0d", i), 32'(valid), 32'd0);
            if (i == DEPTH) drive(1'b0, 1'b0, '0, '0, '0);
        end

        // Every word reads back zero, with a continuous train of valid pulses.
        drive(1'b1, 1'b0, 4'd0, '0, '0);
        for (int j = 1; j < DEPTH + RD_LAT; j++) begin
            @(negedge clk);
            check($sformatf("clr_valid%0d", j), 32'(valid), 32'(j >= RD_LAT));
            if (j >= RD_LAT) begin
                check($sformatf("clr_data%0d", j - RD_LAT), dataout, 32'd0);
`ifdef MEM_PARITY_EN
                check($sformatf("clr_perr%0d", j - RD_LAT), 32'(parity_err), 32'd0);
`endif
            end
            if (j < DEPTH) drive(1'b1, 1'b0, 4'(j), '0, '0);
            else           drive(1'b0, 1'b0, '0, '0, '0);
        end

`ifdef MEM_PARITY_EN
        // Injected parity flip on lane 0 is reported with the read.
        par_inj = 4'b0001;
        drive(1'b1, 1'b1, 4'd3, 32'h0000_005A, 4'b0001);
        @(negedge clk);
        par_inj  = 4'b0000;
        exp_perr = 1'b1;
        read_chk("par_inj", 4'd3, 32'h0000_005A);

        // Rewriting with correct parity clears the error.
        drive(1'b1, 1'b1, 4'd3, 32'h0000_005A, 4'b0001);
        @(negedge clk);
        exp_perr = 1'b0;
        read_chk("par_ok", 4'd3, 32'h0000_005A);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
